axi_line_fetch: RTL and testbench

//  AXI4 read master feeding the HDMI 1080p scan-out stage: on each line request, burst-reads one

---
 rtl/axi_line_fetch.sv | 127 ++++++++++++
 tb/tb_axi_line_fetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_line_fetch.sv
// rtl/axi_line_fetch.sv - AXI4 burst reader that fetches one display line into the cacheline BRAM
// Optional feature macro: AXI_LINE_FETCH_ERR_CHECK_EN (sticky rresp/rlast error flag)
module axi_line_fetch #(
  parameter logic [31:0] FB_BASE    = 32'h1000_0000,
  parameter int          LINE_WORDS = 960,
  parameter int          BURST_LEN  = 16,
  parameter int          LINES      = 1080
) (
  input  logic        system_clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        txn_request,
  output logic        reads_done,
  output logic        wea,
  output logic [31:0] dina,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      state, state_nx;
  logic        req_d;
  logic        rewind_pend;
  logic [10:0] line_ptr;
  logic [5:0]  burst_cnt;
  logic [3:0]  beat_cnt;
  logic        beat_ok;
  logic        last_beat;
  logic        last_burst;

  assign beat_ok    = m_axi_rvalid & m_axi_rready;
  assign last_beat  = (beat_cnt == 4'(BURST_LEN - 1));
  assign last_burst = (burst_cnt == 6'(LINE_WORDS / BURST_LEN - 1));

  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  // Address derives from line/burst counters, which never change while in ADDR.
  assign m_axi_araddr  = FB_BASE
                       + (32'(line_ptr) * 32'(LINE_WORDS * 4))
                       + (32'(burst_cnt) * 32'(BURST_LEN * 4));

  // State register.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and handshake outputs; beat count (not rlast) closes each burst.
  always_comb begin
    state_nx      = state;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    reads_done    = 1'b0;
    case (state)
      IDLE: if (txn_request && !req_d) state_nx = ADDR;
      ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nx = DATA;
      end
      DATA: begin
        m_axi_rready = 1'b1;
        if (beat_ok && last_beat) state_nx = last_burst ? DONE : ADDR;
      end
      DONE: begin
        reads_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counters, BRAM write port, request edge detect and line pointer / rewind handling.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      req_d       <= 1'b0;
      wea         <= 1'b0;
      dina        <= 32'd0;
      beat_cnt    <= 4'd0;
      burst_cnt   <= 6'd0;
      line_ptr    <= 11'd0;
      rewind_pend <= 1'b0;
    end else begin
      req_d <= txn_request;
      wea   <= beat_ok;
      if (beat_ok) begin
        dina     <= m_axi_rdata;
        beat_cnt <= last_beat ? 4'd0 : beat_cnt + 4'd1;
        if (last_beat && !last_burst) burst_cnt <= burst_cnt + 6'd1;
      end
      if (state == DONE) begin
        if (rewind_pend || frame_start)        line_ptr <= 11'd0;
        else if (line_ptr == 11'(LINES - 1))   line_ptr <= 11'd0;
        else                                   line_ptr <= line_ptr + 11'd1;
        rewind_pend <= 1'b0;
        burst_cnt   <= 6'd0;
      end else if (frame_start) begin
        if (state == IDLE) line_ptr    <= 11'd0;
        else               rewind_pend <= 1'b1;
      end
    end
  end

`ifdef AXI_LINE_FETCH_ERR_CHECK_EN
  // Sticky flag for error responses or rlast out of step with the beat count.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else if (beat_ok && ((m_axi_rresp != 2'b00) || (m_axi_rlast != last_beat))) err <= 1'b1;
  end
`else
  logic unused_resp;
  assign unused_resp = ^{m_axi_rresp, m_axi_rlast};
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_axi_line_fetch.sv
// tb/tb_axi_line_fetch.sv - self-checking bench for axi_line_fetch with an AXI slave/scoreboard model
`timescale 1ns/1ps
module tb_axi_line_fetch;
  localparam logic [31:0] FB = 32'h1000_0000;
  localparam int LW = 960;
  localparam int BL = 16;
  localparam int NL = 10;
  localparam int NB = LW / BL;
`ifdef AXI_LINE_FETCH_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        system_clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        txn_request = 1'b0;
  logic        reads_done, wea, m_axi_arvalid, m_axi_rready, err;
  logic [31:0] dina, m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = 32'd0;
  logic [1:0]  m_axi_rresp = 2'b00;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;

  axi_line_fetch #(.FB_BASE(FB), .LINE_WORDS(LW), .BURST_LEN(BL), .LINES(NL)) dut (
    .system_clk(system_clk), .reset(reset), .frame_start(frame_start), .txn_request(txn_request),
    .reads_done(reads_done), .wea(wea), .dina(dina),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .err(err)
  );

  always #5 system_clk = ~system_clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave knobs and scoreboard state (line-level view: data word == its byte address)
  int          ar_delay_k = 0;
  int          rv_mode_k = 0;
  int          err_beat_k = -1;
  logic [31:0] exp_base = FB;
  int          ar_n = 0, wea_n = 0, done_n = 0, r_burst = 0;
  logic [31:0] ar_q[$];
  int          beat = 0, ar_wait = 0;
  logic [31:0] held = 32'd0;
  bit          tog = 1'b0;
  int          model_line = 0;
  bit          err_sticky = 1'b0;

  // AXI slave and output monitor, both acting on the falling edge
  always @(negedge system_clk) begin
    if (reset) begin
      ar_q.delete();
      beat = 0; ar_wait = 0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      m_axi_rresp = 2'b00; m_axi_rdata = 32'd0;
    end else begin
      tog = !tog;
      if (ar_q.size() > 0) begin
        case (rv_mode_k)
          0:       m_axi_rvalid = 1'b1;
          1:       m_axi_rvalid = tog;
          default: m_axi_rvalid = 1'($urandom_range(0, 1));
        endcase
        m_axi_rdata = ar_q[0] + 32'(beat * 4);
        m_axi_rlast = (beat == BL - 1);
        m_axi_rresp = (r_burst == 0 && beat == err_beat_k) ? 2'b10 : 2'b00;
        if (m_axi_rvalid && m_axi_rready) begin
          beat++;
          if (beat == BL) begin
            beat = 0;
            void'(ar_q.pop_front());
            r_burst++;
          end
        end
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        m_axi_rresp = 2'b00;
      end
      if (m_axi_arvalid) begin
        if (ar_wait == 0) held = m_axi_araddr;
        else check("araddr_stable", m_axi_araddr, held);
        m_axi_arready = (ar_wait >= ar_delay_k);
        if (m_axi_arready) begin
          check("araddr", m_axi_araddr, exp_base + 32'(ar_n * 64));
          ar_q.push_back(m_axi_araddr);
          ar_n++;
          ar_wait = 0;
        end else begin
          ar_wait++;
        end
      end else begin
        m_axi_arready = 1'b0;
        ar_wait = 0;
      end
    end
    if (wea) begin
      check("dina", dina, exp_base + 32'(wea_n * 4));
      wea_n++;
    end
    if (reads_done) begin
      check("done_with_last_wea", {30'd0, wea, 1'(wea_n == LW)}, 32'd3);
      done_n++;
    end
  end

  // One line fetch against the line-level model; base is the expected line byte address
  task automatic do_line(input int ard, input int rvm, input int fs_beat, input bit fs_done,
                         input bit retrig, input int eb, input logic [31:0] base, input string tag);
    int cyc = 0;
    bit seen = 1'b0;
    bit fs_set = 1'b0;
    ar_delay_k = ard; rv_mode_k = rvm; err_beat_k = eb; exp_base = base;
    ar_n = 0; wea_n = 0; done_n = 0; r_burst = 0;
    @(negedge system_clk); #1;
    txn_request = 1'b1;
    while (!seen && cyc < 6000) begin
      @(negedge system_clk); #1;
      cyc++;
      frame_start = 1'b0;
      if (!retrig && cyc == 3) txn_request = 1'b0;
      if (retrig) txn_request = !(wea_n >= 100 && wea_n < 104);
      if (fs_beat >= 0 && wea_n >= fs_beat && !fs_set) begin
        frame_start = 1'b1;
        fs_set = 1'b1;
      end
      if (done_n > 0) begin
        seen = 1'b1;
        if (fs_done) frame_start = 1'b1;
      end
    end
    @(negedge system_clk); #1;
    frame_start = 1'b0;
    txn_request = 1'b0;
    check({tag, "_completed"}, 32'(seen), 32'd1);
    repeat (40) @(negedge system_clk);
    #1;
    check({tag, "_ar_count"}, ar_n, NB);
    check({tag, "_wea_count"}, wea_n, LW);
    check({tag, "_done_count"}, done_n, 1);
    if (eb >= 0 && ERR_EN) err_sticky = 1'b1;
    check({tag, "_err"}, 32'(err), 32'(err_sticky));
    model_line = (fs_beat >= 0 || fs_done) ? 0 : (int'((base - FB) / 32'(LW * 4)) + 1) % NL;
  endtask

  typedef struct {
    int          ard;
    int          rvm;
    int          fs_beat;
    bit          fs_done;
    logic [31:0] exp_first;
  } vec_t;
  vec_t vec[11];

  initial begin
    vec[0]  = '{0, 0, -1, 1'b0, 32'h1000_0000};
    vec[1]  = '{5, 1, -1, 1'b0, 32'h1000_0F00};
    vec[2]  = '{int'($urandom_range(0, 3)), 2, -1, 1'b0, 32'h1000_1E00};
    vec[3]  = '{0, 0, -1, 1'b0, 32'h1000_2D00};
    vec[4]  = '{int'($urandom_range(0, 3)), 2, -1, 1'b0, 32'h1000_3C00};
    vec[5]  = '{1, 0, -1, 1'b0, 32'h1000_4B00};
    vec[6]  = '{0, 0, -1, 1'b0, 32'h1000_5A00};
    vec[7]  = '{2, 0, 500, 1'b0, 32'h1000_6900};
    vec[8]  = '{0, 0, -1, 1'b0, 32'h1000_0000};
    vec[9]  = '{0, 0, -1, 1'b1, 32'h1000_0F00};
    vec[10] = '{0, 0, -1, 1'b0, 32'h1000_0000};

    @(negedge system_clk); #1;
    check("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
    check("rst_rready", 32'(m_axi_rready), 32'd0);
    check("rst_wea", 32'(wea), 32'd0);
    check("rst_dina", dina, 32'd0);
    check("rst_reads_done", 32'(reads_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_araddr", m_axi_araddr, FB);
    check("arlen", 32'(m_axi_arlen), 32'd15);
    check("arsize", 32'(m_axi_arsize), 32'd2);
    check("arburst", 32'(m_axi_arburst), 32'd1);
    repeat (2) @(negedge system_clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 11; i++)
      do_line(vec[i].ard, vec[i].rvm, vec[i].fs_beat, vec[i].fs_done, 1'b0, -1,
              vec[i].exp_first, $sformatf("vec%0d", i));

    // Random slave timing through the rest of the frame, then the wrap back to line 0
    for (int i = 0; i < NL - 1; i++)
      do_line(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), -1, 1'b0, 1'b0, -1,
              FB + 32'(model_line * LW * 4), $sformatf("rnd%0d", i));
    check("wrap_model", model_line, 0);
    do_line(0, 0, -1, 1'b0, 1'b0, -1, FB, "wrap");

    // frame_start while idle rewinds at once; a re-raised request mid-line must be ignored
    @(negedge system_clk); #1 frame_start = 1'b1;
    @(negedge system_clk); #1 frame_start = 1'b0;
    do_line(0, 2, -1, 1'b0, 1'b1, -1, FB, "idle_rewind_retrig");

    // Error response on beat 3 of burst 0
    do_line(0, 0, -1, 1'b0, 1'b0, 3, FB + 32'(model_line * LW * 4), "err_resp");

    // Reset in the middle of burst 0
    begin
      int cyc = 0;
      ar_delay_k = 0; rv_mode_k = 0; err_beat_k = -1; exp_base = FB + 32'(model_line * LW * 4);
      ar_n = 0; wea_n = 0; done_n = 0; r_burst = 0;
      txn_request = 1'b1;
      while (wea_n < 8 && cyc < 200) begin
        @(negedge system_clk); #1;
        cyc++;
      end
      check("rst_mid_reached", 32'(wea_n >= 8), 32'd1);
      reset = 1'b1;
      #1;
      check("rst_mid_arvalid", 32'(m_axi_arvalid), 32'd0);
      check("rst_mid_rready", 32'(m_axi_rready), 32'd0);
      check("rst_mid_wea", 32'(wea), 32'd0);
      check("rst_mid_err", 32'(err), 32'd0);
      check("rst_mid_araddr", m_axi_araddr, FB);
      txn_request = 1'b0;
      err_sticky = 1'b0;
      repeat (2) @(negedge system_clk);
      #1 reset = 1'b0;
      model_line = 0;
    end
    do_line(0, 0, -1, 1'b0, 1'b0, -1, FB, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
